// File: rtl/ddmi_pkg.sv
// Shared timing defaults, FSM encoding and blanking value for the ddmi output block.
package ddmi_pkg;

  // 640x480@60 defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam logic [23:0] BLANK_RGB = 24'h000000;

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/ddmi_sync_gen.sv
// h/v position counters (stage 0) and registered region decode (stage 1).
module ddmi_sync_gen
  import ddmi_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = DEF_CW
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          run_i,
  output logic          eof_o,
  output logic          act_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          fs_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_params
    $error("ddmi_sync_gen: illegal timing parameters");
  end

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          act_q, hs_q, vs_q, fs_q;
  logic [CW-1:0] x_q, y_q;
  logic          in_hs, in_vs;

  assign eof_o = (h_q == H_LAST) && (v_q == V_LAST);
  assign in_hs = (h_q >= HS_LO) && (h_q <= HS_HI);
  assign in_vs = (v_q >= VS_LO) && (v_q <= VS_HI);

  // Counters only move while running; outside that they sit at the origin.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_i) begin
      h_d = h_q + CW'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      act_q <= 1'b0;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      act_q <= run_i && (h_q < H_ACT) && (v_q < V_ACT);
      hs_q  <= in_hs ? HSYNC_POL : ~HSYNC_POL;
      vs_q  <= in_vs ? VSYNC_POL : ~VSYNC_POL;
      fs_q  <= run_i && (h_q == '0) && (v_q == '0);
      x_q   <= h_q;
      y_q   <= v_q;
    end
  end

  assign act_o = act_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;
  assign fs_o  = fs_q;
  assign x_o   = x_q;
  assign y_o   = y_q;

endmodule

// File: rtl/ddmi_timing_ctrl.sv
// Video timing controller: run/stop FSM, FWFT pixel pop, underflow flag and aligned output stage.
module ddmi_timing_ctrl
  import ddmi_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = DEF_CW
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          en,
  input  logic [23:0]   pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          underflow_clr,
  output logic [23:0]   rgb,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          running,
  output logic          underflow
);

  state_e        state_q, state_d;
  logic          eof, act1, hs1, vs1, fs1;
  logic [CW-1:0] x1, y1;

  logic [23:0]   rgb_q;
  logic          de_q, hsync_q, vsync_q, fs_q, uf_q;
  logic [CW-1:0] x_q, y_q;

  assign running = (state_q != IDLE);

  ddmi_sync_gen #(
    .H_ACTIVE (H_ACTIVE),  .H_FP   (H_FP),   .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE),  .V_FP   (V_FP),   .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .CW(CW)
  ) u_sync (
    .clk_pixel(clk_pixel),
    .rst      (rst),
    .run_i    (running),
    .eof_o    (eof),
    .act_o    (act1),
    .hs_o     (hs1),
    .vs_o     (vs1),
    .fs_o     (fs1),
    .x_o      (x1),
    .y_o      (y1)
  );

  // Stopping lets the current frame finish; the counters wrap to the origin on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en) state_d = RUN;
      RUN:      if (!en) state_d = STOPPING;
      STOPPING: if (en) state_d = RUN;
                else if (eof) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign pix_ready = act1;

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      rgb_q   <= BLANK_RGB;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      uf_q    <= 1'b0;
    end else begin
      rgb_q   <= (act1 && pix_valid) ? pix_data : BLANK_RGB;
      de_q    <= act1;
      hsync_q <= hs1;
      vsync_q <= vs1;
      fs_q    <= fs1;
      x_q     <= x1;
      y_q     <= y1;
      // A starved pop in the same cycle as a clear still latches the flag.
      if (act1 && !pix_valid) uf_q <= 1'b1;
      else if (underflow_clr) uf_q <= 1'b0;
    end
  end

  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_ddmi_timing_ctrl.sv
// Directed bench for ddmi_timing_ctrl with an 8x6 total / 4x3 active raster.
module tb_ddmi_timing_ctrl;

  localparam int CW = 12;

  logic          clk_pixel = 1'b0;
  logic          rst, en, pix_valid, underflow_clr;
  logic [23:0]   pix_data;
  logic          pix_ready;
  logic [23:0]   rgb;
  logic          de, hsync, vsync, frame_start, running, underflow;
  logic [CW-1:0] x, y;
  logic [11:0]   pix_cnt = '0;

  int n_vec = 0;
  int n_err = 0;
  int exp_pix = 0;

  ddmi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW)
  ) dut (
    .clk_pixel    (clk_pixel),
    .rst          (rst),
    .en           (en),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .underflow_clr(underflow_clr),
    .rgb          (rgb),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .running      (running),
    .underflow    (underflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  // FWFT source: presents the next word until it is popped.
  always @(posedge clk_pixel)
    if (pix_ready && pix_valid) pix_cnt <= pix_cnt + 12'd1;
  assign pix_data = {8'hA5, 4'h0, pix_cnt};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic bit act_pos(input int q);
    return ((q % 8) < 4) && ((q / 8) < 3);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".de"},    32'(de), 32'd0);
    chk({tag, ".rgb"},   32'(rgb), 32'd0);
    chk({tag, ".hs"},    32'(hsync), 32'd1);
    chk({tag, ".vs"},    32'(vsync), 32'd1);
    chk({tag, ".fs"},    32'(frame_start), 32'd0);
    chk({tag, ".rdy"},   32'(pix_ready), 32'd0);
    chk({tag, ".run"},   32'(running), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pix_valid = 1'b0; underflow_clr = 1'b0;
    #3;
    chk_quiet("rst");
    chk("rst.x", 32'(x), 32'd0);
    chk("rst.y", 32'(y), 32'd0);
    chk("rst.uf", 32'(underflow), 32'd0);
    @(negedge clk_pixel);
    rst = 1'b0;

    repeat (20) tick();
    chk_quiet("idle");

    // Enable: RUN next edge, stage 1 after that, first output after that.
    en = 1'b1; pix_valid = 1'b1;
    tick();
    chk("start.run", 32'(running), 32'd1);
    chk("start.rdy0", 32'(pix_ready), 32'd0);
    tick();
    chk("start.rdy1", 32'(pix_ready), 32'd1);
    chk("start.fs0", 32'(frame_start), 32'd0);
    tick();

    // Three frames of output positions; starves at 58 and 65, stop request from 105.
    for (int p = 0; p < 144; p++) begin
      int q;
      bit a, st;
      q  = p % 48;
      a  = act_pos(q);
      st = (p == 58) || (p == 65);
      chk($sformatf("de@%0d", p), 32'(de), 32'(a));
      chk($sformatf("hs@%0d", p), 32'(hsync), 32'(!((q % 8) == 5 || (q % 8) == 6)));
      chk($sformatf("vs@%0d", p), 32'(vsync), 32'((q / 8) != 4));
      chk($sformatf("x@%0d", p), 32'(x), 32'(q % 8));
      chk($sformatf("y@%0d", p), 32'(y), 32'(q / 8));
      chk($sformatf("fs@%0d", p), 32'(frame_start), 32'(q == 0));
      if (a && !st) begin
        chk($sformatf("rgb@%0d", p), 32'(rgb), {8'h00, 8'hA5, 4'h0, 12'(exp_pix)});
        exp_pix++;
      end else begin
        chk($sformatf("rgb@%0d", p), 32'(rgb), 32'd0);
      end
      chk($sformatf("rdy@%0d", p), 32'(pix_ready), 32'((p < 143) && act_pos((p + 1) % 48)));
      chk($sformatf("run@%0d", p), 32'(running), 32'(p < 142));
      chk($sformatf("uf@%0d", p), 32'(underflow),
          32'(((p >= 58) && (p < 60)) || ((p >= 65) && (p < 71))));
      pix_valid     = !((p + 1 == 58) || (p + 1 == 65));
      underflow_clr = (p == 59) || (p == 64) || (p == 70);
      en            = !((p == 99) || (p == 100) || (p >= 105));
      tick();
    end

    for (int i = 0; i < 5; i++) begin
      chk_quiet($sformatf("stop%0d", i));
      tick();
    end
    chk("pops", 32'(pix_cnt), 32'd34);

    // Restart, starve the second pixel, then reset mid-frame at h=2,v=2.
    en = 1'b1; pix_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("re.fs", 32'(frame_start), 32'd1);
    chk("re.rgb0", 32'(rgb), 32'hA5_0022);
    pix_valid = 1'b0;
    tick();
    pix_valid = 1'b1;
    chk("re.de1", 32'(de), 32'd1);
    chk("re.rgb1", 32'(rgb), 32'd0);
    chk("re.uf", 32'(underflow), 32'd1);
    repeat (15) tick();
    chk("pre.x", 32'(x), 32'd0);
    chk("pre.y", 32'(y), 32'd2);
    chk("pre.de", 32'(de), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_quiet("arst");
    chk("arst.x", 32'(x), 32'd0);
    chk("arst.y", 32'(y), 32'd0);
    chk("arst.uf", 32'(underflow), 32'd0);
    tick();
    chk("arst.hold", 32'(running), 32'd0);
    @(negedge clk_pixel);
    rst = 1'b0;
    tick();
    chk("rel.run", 32'(running), 32'd1);
    chk("rel.fs0", 32'(frame_start), 32'd0);
    tick();
    chk("rel.fs1", 32'(frame_start), 32'd0);
    chk("rel.rdy", 32'(pix_ready), 32'd1);
    tick();
    chk("rel.fs2", 32'(frame_start), 32'd1);
    chk("rel.de", 32'(de), 32'd1);
    chk("rel.x", 32'(x), 32'd0);
    chk("rel.y", 32'(y), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
